// File: rtl/perf_counter_mmio_pkg.sv
// Shared definitions for the perf counter MMIO block: access FSM states,
// register offsets (relative to BASE_ADDR) and CTRL/STATUS bit positions.
package perf_counter_mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURE   = 2'd1,
    ST_RESP      = 2'd2,
    ST_WAIT_DROP = 2'd3
  } state_t;

  localparam logic [15:0] CTRL_OFS   = 16'h0010;
  localparam logic [15:0] STATUS_OFS = 16'h0012;
  localparam logic [15:0] LAST_OFS   = STATUS_OFS;

  localparam int CTRL_COR_BIT   = 0;  // clear-on-read enable
  localparam int CTRL_MASK_LSB  = 8;  // write-1-to-pulse clear mask [15:8]
  localparam int STATUS_COR_BIT = 0;  // mirror of CTRL.COR
  localparam int STATUS_SAT_LSB = 8;  // sticky saturate flags [15:8]

endpackage

// File: rtl/perf_counter_mmio_sat_flags.sv
// perf_sat_flags: NUM_CNT sticky saturate flags.
//   clk, reset : clock, synchronous active-high reset
//   i_set      : per-flag set request (counter is all-ones this cycle)
//   i_clr      : per-flag clear mask
//   o_flags    : current flag state
// A flag that is set and cleared in the same cycle stays set.
module perf_sat_flags #(
  parameter int NUM_CNT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CNT-1:0] i_set,
  input  logic [NUM_CNT-1:0] i_clr,
  output logic [NUM_CNT-1:0] o_flags
);

  logic [NUM_CNT-1:0] r_flags;

  always_ff @(posedge clk) begin
    if (reset) r_flags <= '0;
    else       r_flags <= (r_flags & ~i_clr) | i_set;
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/perf_counter_mmio.sv
// perf_counter_mmio: CPU-visible window onto NUM_CNT live event counters.
//   clk, reset          : clock, synchronous active-high reset
//   mem_read/mem_write  : CPU request, held until mem_resp
//   mem_address         : byte address (bit 0 ignored)
//   mem_wdata           : write data
//   cnt_values          : live counter values, counter i at [i*CNT_W +: CNT_W]
//   hit                 : request targets this window (combinational)
//   mem_rdata, mem_resp : read data and one-cycle completion strobe
//   cnt_clear           : one-cycle clear pulse per counter
// Map: counter i at +2i, CTRL at +0x10, STATUS at +0x12.
module perf_counter_mmio
  import perf_counter_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFFE0,
  parameter int          NUM_CNT   = 8,
  parameter int          CNT_W     = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [15:0]              mem_address,
  input  logic [15:0]              mem_wdata,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_values,
  output logic                     hit,
  output logic [15:0]              mem_rdata,
  output logic                     mem_resp,
  output logic [NUM_CNT-1:0]       cnt_clear
);

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_ofs;
  logic               r_is_rd;
  logic [15:0]        r_wdata;
  logic               r_cor;
  logic [15:0]        r_snap;
  logic [NUM_CNT-1:0] r_clr_pend;
  logic [NUM_CNT-1:0] r_sat_clr;

  logic [15:0]        w_ofs;
  logic [15:0]        w_rd_val;
  logic [NUM_CNT-1:0] w_slot;
  logic [NUM_CNT-1:0] w_sat_set;
  logic [NUM_CNT-1:0] w_sat;
  logic               w_unused;

  // Offset from the (even) base; addresses below the base wrap to large
  // values, so a single unsigned compare bounds both ends of the window.
  assign w_ofs = (mem_address & 16'hFFFE) - (BASE_ADDR & 16'hFFFE);
  assign hit   = (w_ofs <= LAST_OFS) && (mem_read || mem_write);

  // Only COR and the clear mask of the latched write data are consumed.
  assign w_unused = ^r_wdata;

  always_comb begin
    w_sat_set = '0;
    for (int i = 0; i < NUM_CNT; i++) w_sat_set[i] = &cnt_values[i*CNT_W +: CNT_W];
  end

  perf_sat_flags #(.NUM_CNT(NUM_CNT)) u_sat (
    .clk    (clk),
    .reset  (reset),
    .i_set  (w_sat_set),
    .i_clr  ((r_state == ST_RESP) ? r_sat_clr : '0),
    .o_flags(w_sat)
  );

  // Read mux on the latched offset; unmatched offsets fall through to zero.
  always_comb begin
    w_rd_val = '0;
    w_slot   = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      w_slot[i] = (r_ofs == 16'(2*i));
      if (w_slot[i]) w_rd_val = 16'(cnt_values[i*CNT_W +: CNT_W]);
    end
    if (r_ofs == CTRL_OFS) w_rd_val[CTRL_COR_BIT] = r_cor;
    if (r_ofs == STATUS_OFS) begin
      w_rd_val[STATUS_COR_BIT] = r_cor;
      for (int i = 0; i < NUM_CNT; i++) w_rd_val[STATUS_SAT_LSB+i] = w_sat[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (hit) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE:   w_state_nxt = ST_RESP;
      ST_RESP:      w_state_nxt = ST_WAIT_DROP;
      ST_WAIT_DROP: if (!mem_read && !mem_write) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ofs      <= '0;
      r_is_rd    <= 1'b0;
      r_wdata    <= '0;
      r_cor      <= 1'b0;
      r_snap     <= '0;
      r_clr_pend <= '0;
      r_sat_clr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: if (hit) begin
          r_ofs   <= w_ofs;
          r_is_rd <= mem_read;  // read wins when both are high
          r_wdata <= mem_wdata;
        end
        ST_CAPTURE: begin
          r_clr_pend <= '0;
          r_sat_clr  <= '0;
          if (r_is_rd) begin
            r_snap <= w_rd_val;
            if (r_cor) r_clr_pend <= w_slot;
            // Only flags visible in this snapshot get cleared at RESP.
            if (r_ofs == STATUS_OFS) r_sat_clr <= w_sat;
          end else if (r_ofs == CTRL_OFS) begin
            r_cor      <= r_wdata[CTRL_COR_BIT];
            r_clr_pend <= r_wdata[CTRL_MASK_LSB +: NUM_CNT];
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_resp  = (r_state == ST_RESP);
  assign mem_rdata = r_snap;
  assign cnt_clear = (r_state == ST_RESP) ? r_clr_pend : '0;

endmodule

// File: tb/tb_perf_counter_mmio.sv
module tb_perf_counter_mmio;

  localparam logic [15:0] BASE = 16'hFFE0;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [79:0] cnt_values;
  logic        hit, mem_resp;
  logic [15:0] mem_rdata;
  logic [7:0]  cnt_clear;
  logic        hit4, resp4;
  logic [15:0] rdata4;
  logic [3:0]  clr4;

  always #5 clk = ~clk;

  perf_counter_mmio #(.BASE_ADDR(16'hFFE0), .NUM_CNT(8), .CNT_W(10)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .cnt_values(cnt_values),
    .hit(hit), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .cnt_clear(cnt_clear));

  perf_counter_mmio #(.BASE_ADDR(16'hFFE0), .NUM_CNT(4), .CNT_W(10)) dut4 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .cnt_values(cnt_values[39:0]),
    .hit(hit4), .mem_rdata(rdata4), .mem_resp(resp4), .cnt_clear(clr4));

  typedef struct { logic [15:0] rdata; logic [7:0] clr; } exp_t;
  exp_t sb_q[$];
  exp_t e;

  int n_chk = 0;
  int n_fail = 0;

  logic        o_hit;
  logic [15:0] o_rdata, o_rdata4;
  logic [7:0]  o_clr, o_clr_after;
  int          o_lat;

  function automatic void set_cnt(input int idx, input logic [9:0] v);
    cnt_values[idx*10 +: 10] = v;
  endfunction

  // Drive one request; expected response goes on the scoreboard.
  task automatic issue(input logic rd, input logic wr, input logic [15:0] ofs,
                       input logic [15:0] wd, input logic [15:0] erd, input logic [7:0] eclr);
    sb_q.push_back('{rdata: erd, clr: eclr});
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = BASE + ofs; mem_wdata = wd;
    #1 o_hit = hit;
  endtask

  // Bounded wait for mem_resp, then drop the request and look one cycle later.
  task automatic wait_resp();
    o_lat = -1; o_rdata = 'x; o_rdata4 = 'x; o_clr = 'x;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_resp) begin
        o_lat = c; o_rdata = mem_rdata; o_rdata4 = rdata4; o_clr = cnt_clear;
        break;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    o_clr_after = cnt_clear;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_read = 0; mem_write = 0; mem_address = 0; mem_wdata = 0; cnt_values = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (mem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_resp got %b want 0", mem_resp); end
    n_chk++; if (cnt_clear !== 8'h00) begin n_fail++; $display("FAIL reset_clear got %h want 00", cnt_clear); end
    n_chk++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", mem_rdata); end
    n_chk++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", hit); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [9:0] v;
    int k;
    set_cnt(3, 10'd517);
    issue(1, 0, 16'h0006, 16'h0, 16'h0205, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_hit !== 1'b1) begin n_fail++; $display("FAIL rd517_hit got %b want 1", o_hit); end
    n_chk++; if (o_lat != 2) begin n_fail++; $display("FAIL rd517_latency got %0d want 2", o_lat); end
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL rd517_rdata got %h want %h", o_rdata, e.rdata); end
    n_chk++; if (o_clr !== e.clr) begin n_fail++; $display("FAIL rd517_clear got %h want %h", o_clr, e.clr); end
    for (int n = 0; n < 4; n++) begin
      k = $urandom_range(0, 7);
      v = 10'($urandom_range(0, 1022));
      set_cnt(k, v);
      issue(1, 0, 16'(2*k), 16'h0, {6'b0, v}, 8'h00);
      wait_resp(); e = sb_q.pop_front();
      n_chk++; if (o_rdata !== e.rdata || o_lat != 2) begin
        n_fail++; $display("FAIL rd_rand%0d got %h lat %0d want %h lat 2", k, o_rdata, o_lat, e.rdata);
      end
    end
    set_cnt(1, 10'd33);
    issue(1, 0, 16'h0002, 16'h0, 16'h0021, 8'h00);  // distinct snapshot before dual-request read
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL rd_cnt1 got %h want %h", o_rdata, e.rdata); end
    issue(1, 1, 16'h0006, 16'hFFFF, 16'h0205, 8'h00);  // both high -> read
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL rdwr_both got %h want %h", o_rdata, e.rdata); end
  endtask

  task automatic test_cor();
    issue(0, 1, 16'h0010, 16'h0001, 16'hxxxx, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_clr !== e.clr || o_lat != 2) begin n_fail++; $display("FAIL cor_wr clear %h lat %0d want %h lat 2", o_clr, o_lat, e.clr); end
    set_cnt(2, 10'd9);
    issue(1, 0, 16'h0004, 16'h0, 16'h0009, 8'b0000_0100);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL cor_rdata got %h want %h", o_rdata, e.rdata); end
    n_chk++; if (o_clr !== e.clr) begin n_fail++; $display("FAIL cor_clear got %h want %h", o_clr, e.clr); end
    n_chk++; if (o_clr_after !== 8'h00) begin n_fail++; $display("FAIL cor_clear_after got %h want 00", o_clr_after); end
    issue(1, 0, 16'h0010, 16'h0, 16'h0001, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata || o_clr !== e.clr) begin n_fail++; $display("FAIL cor_ctrl_rd got %h/%h want %h/%h", o_rdata, o_clr, e.rdata, e.clr); end
  endtask

  task automatic test_clear_mask();
    issue(0, 1, 16'h0010, 16'hA500, 16'hxxxx, 8'hA5);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_clr !== e.clr) begin n_fail++; $display("FAIL mask_clear got %h want %h", o_clr, e.clr); end
    n_chk++; if (o_clr_after !== 8'h00) begin n_fail++; $display("FAIL mask_clear_after got %h want 00", o_clr_after); end
    issue(1, 0, 16'h0010, 16'h0, 16'h0000, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL mask_ctrl_rd got %h want %h", o_rdata, e.rdata); end
    issue(0, 1, 16'h0000, 16'hFFFF, 16'hxxxx, 8'h00);  // write to counter slot: ignored
    wait_resp(); e = sb_q.pop_front();
    issue(0, 1, 16'h0012, 16'hFFFF, 16'hxxxx, 8'h00);  // write to STATUS: ignored
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_lat != 2 || o_clr !== e.clr) begin n_fail++; $display("FAIL wr_status lat %0d clear %h want 2/%h", o_lat, o_clr, e.clr); end
    issue(1, 0, 16'h0010, 16'h0, 16'h0000, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL wr_ignored_ctrl got %h want %h", o_rdata, e.rdata); end
  endtask

  task automatic test_status();
    @(negedge clk); set_cnt(7, 10'h3FF);
    @(negedge clk); set_cnt(7, 10'h000);
    issue(1, 0, 16'h0012, 16'h0, 16'h8000, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL status_set got %h want %h", o_rdata, e.rdata); end
    issue(1, 0, 16'h0012, 16'h0, 16'h0000, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL status_cleared got %h want %h", o_rdata, e.rdata); end
    set_cnt(5, 10'h3FF);  // held saturated through the read: set wins over clear
    issue(1, 0, 16'h0012, 16'h0, 16'h2000, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    issue(1, 0, 16'h0012, 16'h0, 16'h2000, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL status_set_wins got %h want %h", o_rdata, e.rdata); end
    set_cnt(5, 10'h000);
    issue(1, 0, 16'h0012, 16'h0, 16'h2000, 8'h00);  // clears flag 5 at RESP
    wait_resp(); e = sb_q.pop_front();
    issue(1, 0, 16'h0012, 16'h0, 16'h0000, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL status_final got %h want %h", o_rdata, e.rdata); end
  endtask

  task automatic test_back_to_back();
    int nresp;
    logic [15:0] got;
    // Held request: one response only.
    sb_q.push_back('{rdata: 16'h0205, clr: 8'h00});
    @(negedge clk); mem_read = 1; mem_write = 0; mem_address = BASE + 16'h0006;
    nresp = 0; got = 'x;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_resp) begin nresp++; got = mem_rdata; end
    end
    mem_read = 0;
    e = sb_q.pop_front();
    n_chk++; if (nresp != 1) begin n_fail++; $display("FAIL held_resp_count got %0d want 1", nresp); end
    n_chk++; if (got !== e.rdata) begin n_fail++; $display("FAIL held_rdata got %h want %h", got, e.rdata); end
    @(negedge clk);
    // Reset during CAPTURE aborts the access and clears CTRL.
    issue(0, 1, 16'h0010, 16'h0001, 16'hxxxx, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    @(negedge clk); mem_read = 1; mem_address = BASE + 16'h0006;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; mem_read = 0;
    nresp = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (mem_resp) nresp++; end
    n_chk++; if (nresp != 0) begin n_fail++; $display("FAIL reset_abort_resp got %0d want 0", nresp); end
    issue(1, 0, 16'h0010, 16'h0, 16'h0000, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata || o_lat != 2) begin n_fail++; $display("FAIL reset_ctrl got %h lat %0d want %h lat 2", o_rdata, o_lat, e.rdata); end
    // Request held across reset is serviced afresh once reset drops.
    @(negedge clk); mem_read = 1; mem_address = BASE + 16'h0006; reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    sb_q.push_back('{rdata: 16'h0205, clr: 8'h00});
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_lat != 2 || o_rdata !== e.rdata) begin n_fail++; $display("FAIL post_reset_held lat %0d rdata %h want 2/%h", o_lat, o_rdata, e.rdata); end
  endtask

  task automatic test_window();
    int nresp;
    @(negedge clk); mem_read = 1; mem_write = 0; mem_address = BASE + 16'h0020;
    #1 o_hit = hit;
    nresp = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (mem_resp) nresp++; end
    mem_read = 0;
    n_chk++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL window_above_hit got %b want 0", o_hit); end
    n_chk++; if (nresp != 0) begin n_fail++; $display("FAIL window_above_resp got %0d want 0", nresp); end
    @(negedge clk); mem_read = 1; mem_address = BASE - 16'h0002;
    #1 o_hit = hit;
    @(negedge clk); mem_read = 0;
    n_chk++; if (o_hit !== 1'b0) begin n_fail++; $display("FAIL window_below_hit got %b want 0", o_hit); end
    repeat (2) @(negedge clk);
    set_cnt(7, 10'h155);
    issue(1, 0, 16'h000E, 16'h0, 16'h0155, 8'h00);
    wait_resp(); e = sb_q.pop_front();
    n_chk++; if (o_rdata !== e.rdata) begin n_fail++; $display("FAIL slot7_n8 got %h want %h", o_rdata, e.rdata); end
    n_chk++; if (o_rdata4 !== 16'h0000) begin n_fail++; $display("FAIL slot7_n4 got %h want 0000", o_rdata4); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_cor();
    test_clear_mask();
    test_status();
    test_back_to_back();
    test_window();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
